conv1_frame_ctrl: RTL and testbench
===================================

# conv1_frame_ctrl

Frame sequencer for the first convolution layer. Buffers one 28x28 binary image arriving over a valid/ready stream, clears the conv-1 line buffer, then bursts the 784 pixels into conv layer 1 on consecutive cycles. It also generates the expected window-valid tag with output row/column, checks it against the layer's own valid, and signals frame completion. Sits between the image source and `conv_layer_1`, and owns that layer's per-frame reset.

## Interface
- `WIDTH`, 28, image columns
- `HEIGHT`, 28, image rows
- `CONV_LAT`, 1, cycles from a pixel sampled by conv-1 to its `valid_out_conv1`; legal range 1..4
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  source pixel valid
- `s_ready`  out  1  controller can accept a pixel
- `s_pixel`  in  1  source pixel (binary)
- `s_last`  in  1  last pixel of frame
- `conv_rst_n`  out  1  to conv-1 `rst_n`; equals `rst_n & conv_clr_n_q`
- `conv_pixel`  out  1  to conv-1 `pixel_in`, registered
- `conv_valid`  in  1  from conv-1 `valid_out_conv1`
- `out_valid`  out  1  expected conv-1 output valid this cycle
- `out_row`  out  5  output row 0..HEIGHT-3
- `out_col`  out  5  output column 0..WIDTH-3
- `out_last`  out  1  with `out_valid` at (25,25)
- `frame_done`  out  1  one-cycle pulse at end of frame
- `err_len`  out  1  one-cycle pulse on frame length error
- `err_sync`  out  1  one-cycle pulse on `conv_valid` != `out_valid`

## Operation
- State machine: IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE.
- Reset: state IDLE. All outputs are 0 except `s_ready` = 1 after reset release. `conv_clr_n_q` is 0 during reset and 1 on the first clock after release. Frame buffer contents are don't-care.
- IDLE/LOAD: `s_ready` = 1. Each beat (`s_valid & s_ready`) writes `fb[wr_idx]` and increments `wr_idx` (10 bits). The first beat moves IDLE→LOAD.
- `s_last` on beat index NPIX-1 (783): go to CLEAR.
- `s_last` on an earlier beat: pulse `err_len`, discard the frame, reset `wr_idx`, go to IDLE.
- Beat index 783 without `s_last`: pulse `err_len`, then treat it as last and go to CLEAR. Subsequent beats belong to the next frame.
- CLEAR: one cycle. `conv_clr_n_q` = 0, `s_ready` = 0. Then go to STREAM.
- STREAM: 784 cycles. `rd_idx` runs 0..783 and `conv_pixel` <= `fb[rd_idx]`. Row/column counters `r`, `c` track `rd_idx`.
  - The tag for pixel (r,c) is 1 iff r>=2 and c>=2, with coordinates (r-2, c-2).
  - The tag passes through a CONV_LAT-deep pipe to `out_valid`/`out_row`/`out_col`/`out_last`.
  - `s_ready` = 0.
- DRAIN: CONV_LAT cycles, flushing the tag pipe. Then go to DONE.
- DONE: `frame_done` = 1 for one cycle, `wr_idx` = 0, go to IDLE.
- Sync check: in STREAM and DRAIN, each cycle with `conv_valid` != `out_valid` pulses `err_sync` the next cycle. The check is off in all other states. A mismatch does not stop the stream.
- Source beats offered outside IDLE/LOAD are not accepted (`s_ready` = 0).
- Reset mid-frame: abort immediately to IDLE. The partial frame is lost, the tag pipe is cleared, and no `frame_done` is issued.

## Timing
- The beat with `s_last` accepted at edge T puts the controller in CLEAR during cycle T+1. `conv_rst_n` is low for that cycle only.
- STREAM covers cycles T+2..T+785. `conv_pixel` for `rd_idx` = k is valid in cycle T+3+k (registered output).
- First `out_valid` (0,0) comes from pixel k=58 (r=2, c=2). `out_last` comes from k=783. Exactly 676 `out_valid` cycles per frame.
- `frame_done` arrives CONV_LAT+1 cycles after the last STREAM cycle. `s_ready` rises the cycle after DONE.
- Minimum frame period is 784 + 1 + 784 + CONV_LAT + 1 cycles.

## Structure
- Package `conv1_ctrl_pkg`:
  - state enum
  - `NPIX` = WIDTH*HEIGHT
  - `OUT_W` = WIDTH-2, `OUT_H` = HEIGHT-2
  - index and coordinate widths
- Sub-module `conv1_pos_counter`: row/column counter with clear and enable. It outputs `r`, `c`, the window-valid tag and the output coordinates. Used once for STREAM.
- Frame buffer is a flat NPIX-bit register; no RAM.

## Test plan
- Normal frame, alternating pixels, CONV_LAT=1, conv-1 attached: 784 beats with `s_last` on 783 → `conv_rst_n` low for 1 cycle; 676 `out_valid`; first at (0,0), `out_last` at (25,25); `frame_done` once; `err_sync` never.
- Short frame, `s_last` on beat 99 → `err_len` pulse, return to IDLE, no CLEAR, no `frame_done`. A following full frame then completes normally.
- Missing `s_last` on beat 783 → `err_len` pulse and the frame still streams; `frame_done` asserted.
- Source throttled: `s_valid` on every third cycle → identical `conv_pixel` sequence and `out_*` timing relative to CLEAR as the unthrottled case.
- Model drives `conv_valid` one cycle early at (0,0) → `err_sync` pulses, the stream continues, `frame_done` asserted.
- `rst_n` asserted at STREAM `rd_idx`=400 → all outputs 0 asynchronously; after release `s_ready` = 1 and no `frame_done`. The next frame completes normally.

Source files
------------

// File: rtl/conv1_ctrl_pkg.sv
// Shared definitions for the conv-1 frame controller: image geometry,
// index/coordinate widths, FSM state encoding and the window-tag payload.
package conv1_ctrl_pkg;

  localparam int unsigned IMG_W   = 28;
  localparam int unsigned IMG_H   = 28;
  localparam int unsigned NPIX    = IMG_W * IMG_H;
  localparam int unsigned OUT_W   = IMG_W - 2;
  localparam int unsigned OUT_H   = IMG_H - 2;
  localparam int unsigned IDX_W   = $clog2(NPIX);
  localparam int unsigned COORD_W = 5;
  localparam int unsigned LAT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Expected conv-1 output tag, delayed alongside the layer's latency.
  typedef struct packed {
    logic               valid;
    logic               last;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/conv1_pos_counter.sv
// Row/column scan counter for the streaming phase.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          zero the counters
//   en           advance one pixel in raster order
//   r, c         current pixel row/column
//   win_valid_c  pixel completes a 3x3 window (r>=2 and c>=2)
//   win_row_c    window output row (r-2)
//   win_col_c    window output column (c-2)
//   win_last_c   pixel is the bottom-right image pixel
module conv1_pos_counter
  import conv1_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = IMG_W,
  parameter int unsigned HEIGHT = IMG_H
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] r,
  output logic [COORD_W-1:0] c,
  output logic               win_valid_c,
  output logic [COORD_W-1:0] win_row_c,
  output logic [COORD_W-1:0] win_col_c,
  output logic               win_last_c
);

  localparam logic [COORD_W-1:0] C_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] R_LAST = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] BORDER = COORD_W'(2);

  // Raster-order position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (en) begin
      if (c == C_LAST) begin
        c <= '0;
        r <= r + COORD_W'(1);
      end else begin
        c <= c + COORD_W'(1);
      end
    end
  end

  // Window tag for the pixel currently addressed
  always_comb begin
    win_valid_c = (r >= BORDER) && (c >= BORDER);
    win_row_c   = r - BORDER;
    win_col_c   = c - BORDER;
    win_last_c  = (r == R_LAST) && (c == C_LAST);
  end

endmodule

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv layer 1: buffers a 28x28 binary image from a
// valid/ready source, pulses conv-1's reset for one cycle, bursts the pixels
// on consecutive cycles, and produces/checks the expected window-valid tag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     source handshake; s_pixel data, s_last end of frame
//   conv_rst_n          per-frame reset to conv-1 (rst_n & local clear)
//   conv_pixel          registered pixel to conv-1
//   conv_valid          conv-1's own output valid
//   out_valid/row/col/last  expected conv-1 output tag
//   frame_done          one-cycle pulse at end of frame
//   err_len             one-cycle pulse on bad frame length
//   err_sync            one-cycle pulse when conv_valid disagreed with out_valid
// WIDTH*HEIGHT must equal the package NPIX; the frame buffer is sized by it.
module conv1_frame_ctrl
  import conv1_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = IMG_W,
  parameter int unsigned HEIGHT   = IMG_H,
  parameter int unsigned CONV_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_pixel,
  input  logic               s_last,
  output logic               conv_rst_n,
  output logic               conv_pixel,
  input  logic               conv_valid,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               out_last,
  output logic               frame_done,
  output logic               err_len,
  output logic               err_sync
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NPIX - 1);
  localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'(CONV_LAT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               conv_clr_n_q, conv_clr_n_d;
  logic               s_ready_q, s_ready_d;
  logic               err_len_q, err_len_d;
  logic               err_sync_q, err_sync_d;
  logic               frame_done_q, frame_done_d;
  logic               conv_pixel_q, conv_pixel_d;
  logic               beat;
  logic [NPIX-1:0]    fb;

  logic [COORD_W-1:0] pos_r, pos_c;
  logic               win_valid_c, win_last_c;
  logic [COORD_W-1:0] win_row_c, win_col_c;
  logic [IDX_W-1:0]   rd_idx_c;

  tag_t               tag_in;
  tag_t               tag_pipe_q [CONV_LAT];

  conv1_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state_q == ST_CLEAR),
    .en          (state_q == ST_STREAM),
    .r           (pos_r),
    .c           (pos_c),
    .win_valid_c (win_valid_c),
    .win_row_c   (win_row_c),
    .win_col_c   (win_col_c),
    .win_last_c  (win_last_c)
  );

  // Read address follows the scan position
  assign rd_idx_c = IDX_W'(pos_r) * IDX_W'(WIDTH) + IDX_W'(pos_c);

  // Next state and registered-output values
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    lat_cnt_d = lat_cnt_q;
    err_len_d = 1'b0;
    beat      = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          beat = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            // A missing s_last here still closes the frame
            err_len_d = !s_last;
            wr_idx_d  = '0;
            state_d   = ST_CLEAR;
          end else if (s_last) begin
            err_len_d = 1'b1;
            wr_idx_d  = '0;
            state_d   = ST_IDLE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: begin
        if (rd_idx_c == LAST_IDX) begin
          lat_cnt_d = '0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lat_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_DONE: begin
        wr_idx_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d    = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    conv_clr_n_d = (state_d != ST_CLEAR);
    frame_done_d = (state_d == ST_DONE);
    conv_pixel_d = (state_q == ST_STREAM) ? fb[rd_idx_c] : 1'b0;
    err_sync_d   = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) &&
                   (conv_valid != out_valid);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_idx_q     <= '0;
      lat_cnt_q    <= '0;
      conv_clr_n_q <= 1'b0;
      s_ready_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_sync_q   <= 1'b0;
      frame_done_q <= 1'b0;
      conv_pixel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      lat_cnt_q    <= lat_cnt_d;
      conv_clr_n_q <= conv_clr_n_d;
      s_ready_q    <= s_ready_d;
      err_len_q    <= err_len_d;
      err_sync_q   <= err_sync_d;
      frame_done_q <= frame_done_d;
      conv_pixel_q <= conv_pixel_d;
    end
  end

  // Frame buffer; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (beat) begin
      fb[wr_idx_q] <= s_pixel;
    end
  end

  // Tag for the pixel being read, zeroed outside valid windows
  always_comb begin
    tag_in = '0;
    if ((state_q == ST_STREAM) && win_valid_c) begin
      tag_in.valid = 1'b1;
      tag_in.last  = win_last_c;
      tag_in.row   = win_row_c;
      tag_in.col   = win_col_c;
    end
  end

  // Delay the tag to line up with conv-1's output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CONV_LAT; i++) begin
        tag_pipe_q[i] <= '0;
      end
    end else begin
      tag_pipe_q[0] <= tag_in;
      for (int i = 1; i < CONV_LAT; i++) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign conv_rst_n = rst_n & conv_clr_n_q;
  assign conv_pixel = conv_pixel_q;
  assign out_valid  = tag_pipe_q[CONV_LAT-1].valid;
  assign out_last   = tag_pipe_q[CONV_LAT-1].last;
  assign out_row    = tag_pipe_q[CONV_LAT-1].row;
  assign out_col    = tag_pipe_q[CONV_LAT-1].col;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Testbench for conv1_frame_ctrl: random and patterned frames, timing and
// tag expectations derived from pixel index arithmetic relative to the CLEAR cycle.
module tb_conv1_frame_ctrl;
  import conv1_ctrl_pkg::*;

  localparam int LAT   = 1;
  localparam int END_J = 786 + LAT;          // first IDLE cycle after DONE, counted from CLEAR
  localparam int J0    = 1 + (2 * IMG_W + 2) + LAT;  // cycle of the (0,0) output

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_pixel = 1'b0;
  logic       s_last = 1'b0;
  logic       conv_valid = 1'b0;
  logic       s_ready, conv_rst_n, conv_pixel, out_valid, out_last;
  logic       frame_done, err_len, err_sync;
  logic [4:0] out_row, out_col;
  logic [17:0] outs;

  int n_chk  = 0;
  int n_fail = 0;

  conv1_frame_ctrl #(
    .WIDTH    (IMG_W),
    .HEIGHT   (IMG_H),
    .CONV_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .s_last     (s_last),
    .conv_rst_n (conv_rst_n),
    .conv_pixel (conv_pixel),
    .conv_valid (conv_valid),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .frame_done (frame_done),
    .err_len    (err_len),
    .err_sync   (err_sync)
  );

  always #5 clk = ~clk;

  assign outs = {s_ready, conv_rst_n, conv_pixel, out_valid, out_last,
                 frame_done, err_len, err_sync, out_row, out_col};

  function automatic logic [NPIX-1:0] rand_img();
    logic [NPIX-1:0] im;
    for (int i = 0; i < NPIX; i++) im[i] = 1'($urandom_range(0, 1));
    return im;
  endfunction

  // Offer nbeats pixels; gap idle cycles precede each beat. Returns in the cycle after the final beat.
  task automatic send_frame(input logic [NPIX-1:0] img, input int nbeats, input int last_at, input int gap);
    for (int b = 0; b < nbeats; b++) begin
      int guard;
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1; s_pixel = img[b]; s_last = (b == last_at);
      guard = 0;
      while (!s_ready && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      n_chk++;
      if (s_ready !== 1'b1) begin
        n_fail++; $display("FAIL beat_ready: beat %0d s_ready=%b required 1", b, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; s_pixel = 1'b0;
  endtask

  // Follow one frame from its CLEAR cycle (j=0) through the first IDLE cycle,
  // acting as conv-1 on conv_valid. abort_at >= 0 asserts rst_n in that cycle.
  task automatic observe(input logic [NPIX-1:0] img, input bit early, input bit offer, input int abort_at);
    int n_valid = 0;
    int n_done  = 0;
    int first_row = -1;
    int first_col = -1;
    for (int j = 0; j <= END_J; j++) begin
      int kp, ko, r, c;
      logic e_pix, e_valid, e_last, e_sync, e_rst, e_rdy, e_done;
      logic [4:0] e_row, e_col;
      kp = j - 2;
      ko = j - 1 - LAT;
      e_pix = 1'b0;
      if (kp >= 0 && kp < NPIX) e_pix = img[kp];
      e_valid = 1'b0; e_last = 1'b0; e_row = '0; e_col = '0;
      if (ko >= 0 && ko < NPIX) begin
        r = ko / IMG_W; c = ko % IMG_W;
        if (r >= 2 && c >= 2) begin
          e_valid = 1'b1; e_row = 5'(r - 2); e_col = 5'(c - 2);
          e_last = (ko == NPIX - 1);
        end
      end
      if (early && j == J0 - 1)  conv_valid = 1'b1;
      else if (early && j == J0) conv_valid = 1'b0;
      else                       conv_valid = e_valid;
      e_sync = early && (j == J0 || j == J0 + 1);
      e_rst  = (j != 0);
      e_rdy  = (j >= END_J);
      e_done = (j == END_J - 1);
      s_valid = offer && (j < END_J);
      s_pixel = j[0];

      if (j == abort_at) begin
        rst_n = 1'b0; s_valid = 1'b0; conv_valid = 1'b0;
        #1;
        n_chk++;
        if (outs !== '0) begin
          n_fail++; $display("FAIL abort_outputs: outputs=%h required 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (s_ready !== 1'b1 || conv_rst_n !== 1'b1) begin
          n_fail++; $display("FAIL abort_release: s_ready=%b conv_rst_n=%b required 1 1", s_ready, conv_rst_n);
        end
        for (int q = 0; q < 800; q++) begin
          n_chk++;
          if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: cycle %0d frame_done=%b out_valid=%b required 0 0", q, frame_done, out_valid);
          end
          @(posedge clk); #1;
        end
        return;
      end

      n_chk++;
      if (conv_rst_n !== e_rst) begin
        n_fail++; $display("FAIL conv_rst_n: j=%0d got %b required %b", j, conv_rst_n, e_rst);
      end
      n_chk++;
      if (s_ready !== e_rdy) begin
        n_fail++; $display("FAIL s_ready: j=%0d got %b required %b", j, s_ready, e_rdy);
      end
      n_chk++;
      if (conv_pixel !== e_pix) begin
        n_fail++; $display("FAIL conv_pixel: j=%0d got %b required %b", j, conv_pixel, e_pix);
      end
      n_chk++;
      if ({out_valid, out_last, out_row, out_col} !== {e_valid, e_last, e_row, e_col}) begin
        n_fail++;
        $display("FAIL out_tag: j=%0d got v=%b l=%b (%0d,%0d) required v=%b l=%b (%0d,%0d)",
                 j, out_valid, out_last, out_row, out_col, e_valid, e_last, e_row, e_col);
      end
      n_chk++;
      if (frame_done !== e_done) begin
        n_fail++; $display("FAIL frame_done: j=%0d got %b required %b", j, frame_done, e_done);
      end
      n_chk++;
      if (err_sync !== e_sync) begin
        n_fail++; $display("FAIL err_sync: j=%0d got %b required %b", j, err_sync, e_sync);
      end
      if (j >= 1) begin
        n_chk++;
        if (err_len !== 1'b0) begin
          n_fail++; $display("FAIL err_len_quiet: j=%0d got %b required 0", j, err_len);
        end
      end
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first_row < 0) begin first_row = out_row; first_col = out_col; end
      end
      if (frame_done === 1'b1) n_done++;
      if (j < END_J) begin @(posedge clk); #1; end
    end
    n_chk++;
    if (n_valid != OUT_W * OUT_H) begin
      n_fail++; $display("FAIL valid_count: got %0d required %0d", n_valid, OUT_W * OUT_H);
    end
    n_chk++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL done_count: got %0d required 1", n_done);
    end
    n_chk++;
    if (first_row != 0 || first_col != 0) begin
      n_fail++; $display("FAIL first_coord: got (%0d,%0d) required (0,0)", first_row, first_col);
    end
  endtask

  // Cycle after the final accepted beat of a good-length frame
  task automatic check_accept(input logic e_err);
    n_chk++;
    if (err_len !== e_err || conv_rst_n !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_entry: err_len=%b conv_rst_n=%b s_ready=%b required %b 0 0", err_len, conv_rst_n, s_ready, e_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: outputs=%h required 0", outs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (s_ready !== 1'b1 || conv_rst_n !== 1'b1 || {out_valid, frame_done, err_len, err_sync} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release: outputs=%h required s_ready=1 conv_rst_n=1 others 0", outs);
    end
  endtask

  task automatic test_normal();
    logic [NPIX-1:0] img;
    for (int i = 0; i < NPIX; i++) img[i] = 1'(i % 2);
    send_frame(img, NPIX, NPIX - 1, 0);
    check_accept(1'b0);
    observe(img, 1'b0, 1'b0, -1);
  endtask

  task automatic test_short_frame();
    logic [NPIX-1:0] img;
    img = rand_img();
    send_frame(img, 100, 99, 0);
    n_chk++;
    if (err_len !== 1'b1 || s_ready !== 1'b1 || conv_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL short_err: err_len=%b s_ready=%b conv_rst_n=%b required 1 1 1", err_len, s_ready, conv_rst_n);
    end
    for (int q = 0; q < 5; q++) begin
      @(posedge clk); #1;
      n_chk++;
      if (err_len !== 1'b0 || conv_rst_n !== 1'b1 || frame_done !== 1'b0 || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL short_idle: cycle %0d err_len=%b conv_rst_n=%b frame_done=%b s_ready=%b required 0 1 0 1",
                 q, err_len, conv_rst_n, frame_done, s_ready);
      end
    end
    img = rand_img();
    send_frame(img, NPIX, NPIX - 1, 0);
    check_accept(1'b0);
    observe(img, 1'b0, 1'b0, -1);
  endtask

  task automatic test_missing_last();
    logic [NPIX-1:0] img;
    img = rand_img();
    send_frame(img, NPIX, -1, 0);
    check_accept(1'b1);
    observe(img, 1'b0, 1'b0, -1);
  endtask

  task automatic test_throttled();
    logic [NPIX-1:0] img;
    img = rand_img();
    send_frame(img, NPIX, NPIX - 1, 2);
    check_accept(1'b0);
    observe(img, 1'b0, 1'b0, -1);
  endtask

  // conv-1 fires (0,0) one cycle early while the source keeps offering beats
  task automatic test_sync_error();
    logic [NPIX-1:0] img;
    img = rand_img();
    send_frame(img, NPIX, NPIX - 1, 0);
    check_accept(1'b0);
    observe(img, 1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_stream();
    logic [NPIX-1:0] img;
    img = rand_img();
    send_frame(img, NPIX, NPIX - 1, 0);
    check_accept(1'b0);
    observe(img, 1'b0, 1'b0, 1 + 400);
    img = rand_img();
    send_frame(img, NPIX, NPIX - 1, 0);
    check_accept(1'b0);
    observe(img, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short_frame();
    test_missing_last();
    test_throttled();
    test_sync_error();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
